// File: rtl/ahbl_dual_master_arb_pkg.sv
// Shared types and constants for the dual-master AHB-Lite arbiter.
//   Width defaults    : SYS_ADDR_WIDTH, SYS_DATA_WIDTH
//   Enumerated types  : htrans_e, hsize_e, arb_owner_e
//   Protection values : HPROT_FETCH, HPROT_DATA
package ahbl_dual_master_arb_pkg;

    localparam int unsigned SYS_ADDR_WIDTH = 32;
    localparam int unsigned SYS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_e;

    localparam logic [3:0] HPROT_FETCH = 4'b0010;
    localparam logic [3:0] HPROT_DATA  = 4'b0011;

endpackage

// File: rtl/ahbl_dual_master_arb_be2size.sv
// Byte-enable to AHB transfer size / low address decode.
//   be      : 4-bit byte enables of a word-aligned access
//   hsize   : transfer size (byte, halfword or word)
//   addr_lo : HADDR[1:0] for the selected lanes
// Patterns that are not a single byte or an aligned halfword fall back to a
// full word access at offset 0.
module ahbl_dual_master_arb_be2size
    import ahbl_dual_master_arb_pkg::*;
(
    input  logic [3:0] be,
    output hsize_e     hsize,
    output logic [1:0] addr_lo
);

    always_comb begin
        hsize   = HSIZE_WORD;
        addr_lo = 2'b00;
        case (be)
            4'b0001: begin hsize = HSIZE_BYTE; addr_lo = 2'b00; end
            4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
            4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
            4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
            4'b0011: begin hsize = HSIZE_HALF; addr_lo = 2'b00; end
            4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahbl_dual_master_arb.sv
// Shares one AHB-Lite master port between the Ibex instruction-fetch and
// LSU req/gnt/rvalid interfaces. One address phase is granted per cycle and
// the single outstanding data phase is routed back to its owner.
//   sys_clk_i / sys_rstn_i : clock, synchronous active-low reset
//   instr_*                : fetch request/grant/response interface
//   data_*                 : LSU request/grant/response interface
//   ahbl_*                 : AHB-Lite master port
// Build option: define ARB_ROUND_ROBIN_EN to alternate between ports when
// both request; otherwise the LSU always has priority over fetch.
module ahbl_dual_master_arb
    import ahbl_dual_master_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SYS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SYS_DATA_WIDTH
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic [ADDR_WIDTH-1:0] ahbl_haddr_o,
    output logic [2:0]            ahbl_hburst_o,
    output logic                  ahbl_hmastlock_o,
    output logic [3:0]            ahbl_hprot_o,
    output logic [2:0]            ahbl_hsize_o,
    output logic [1:0]            ahbl_htrans_o,
    output logic [DATA_WIDTH-1:0] ahbl_hwdata_o,
    output logic                  ahbl_hwrite_o,
    input  logic [DATA_WIDTH-1:0] ahbl_hrdata_i,
    input  logic                  ahbl_hready_i,
    input  logic                  ahbl_hresp_i
);

    logic                  dp_valid;
    arb_owner_e            dp_owner;
    logic [DATA_WIDTH-1:0] hwdata;
    arb_owner_e            winner;
    logic                  any_req;
    logic                  err_first;
    logic                  addr_ok;
    logic                  grant;
    logic                  dp_rvalid;
    hsize_e                be_size;
    logic [1:0]            be_lo;
    logic                  unused_addr_bits;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_e            rr_last;
`endif

    // Byte lanes come from data_be_i, so the core's low address bits are dropped.
    assign unused_addr_bits = ^data_addr_i[1:0];

    ahbl_dual_master_arb_be2size u_be2size (
        .be      (data_be_i),
        .hsize   (be_size),
        .addr_lo (be_lo)
    );

    // First cycle of a two-cycle ERROR response (HRESP=1, HREADY=0).
    assign err_first = ahbl_hresp_i & ~ahbl_hready_i;
    assign addr_ok   = ahbl_hready_i & ~err_first;
    assign any_req   = instr_req_i | data_req_i;
    assign grant     = any_req & addr_ok;

    always_comb begin
        winner = OWNER_INSTR;
        if (data_req_i) begin
            winner = OWNER_DATA;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (data_req_i && instr_req_i) begin
            winner = (rr_last == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
        end
`endif
    end

    assign data_gnt_o  = grant & (winner == OWNER_DATA);
    assign instr_gnt_o = grant & (winner == OWNER_INSTR);

    // Address-phase outputs track the current winner even through wait
    // states, so a core holding its request keeps HADDR stable.
    always_comb begin
        ahbl_htrans_o = HTRANS_IDLE;
        ahbl_haddr_o  = '0;
        ahbl_hwrite_o = 1'b0;
        ahbl_hsize_o  = HSIZE_WORD;
        ahbl_hprot_o  = HPROT_FETCH;
        if (any_req) begin
            if (!err_first) begin
                ahbl_htrans_o = HTRANS_NONSEQ;
            end
            if (winner == OWNER_DATA) begin
                ahbl_haddr_o  = {data_addr_i[ADDR_WIDTH-1:2], be_lo};
                ahbl_hwrite_o = data_we_i;
                ahbl_hsize_o  = be_size;
                ahbl_hprot_o  = HPROT_DATA;
            end else begin
                ahbl_haddr_o  = instr_addr_i;
            end
        end
    end

    assign ahbl_hburst_o    = 3'b000;
    assign ahbl_hmastlock_o = 1'b0;
    assign ahbl_hwdata_o    = hwdata;

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            dp_valid <= 1'b0;
            dp_owner <= OWNER_INSTR;
            hwdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last  <= OWNER_INSTR;
`endif
        end else if (ahbl_hready_i) begin
            dp_valid <= grant;
            if (grant) begin
                dp_owner <= winner;
                if (winner == OWNER_DATA) begin
                    hwdata <= data_wdata_i;
                end
`ifdef ARB_ROUND_ROBIN_EN
                rr_last <= winner;
`endif
            end
        end
    end

    assign dp_rvalid      = dp_valid & ahbl_hready_i;
    assign instr_rvalid_o = dp_rvalid & (dp_owner == OWNER_INSTR);
    assign data_rvalid_o  = dp_rvalid & (dp_owner == OWNER_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? ahbl_hrdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? ahbl_hrdata_i : '0;
    assign instr_err_o    = ahbl_hresp_i & instr_rvalid_o;
    assign data_err_o     = ahbl_hresp_i & data_rvalid_o;

endmodule

// File: tb/tb_ahbl_dual_master_arb.sv
// Self-checking bench for ahbl_dual_master_arb: a table of directed cycles
// with constant expectations, hand-written wait-state and arbitration
// sequences, and randomized cycles checked against a behavioural model.
module tb_ahbl_dual_master_arb;

    localparam logic       Y   = 1'b1;
    localparam logic       N   = 1'b0;
    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [2:0] SZB = 3'b000;
    localparam logic [2:0] SZH = 3'b001;
    localparam logic [2:0] SZW = 3'b010;
    localparam logic [3:0] PF  = 4'b0010;
    localparam logic [3:0] PD  = 4'b0011;
    localparam int NV = 18;

    typedef struct packed {
        logic        rstn;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] hrdata;
        logic        hready;
        logic        hresp;
    } in_t;

    typedef struct packed {
        logic        dgnt;
        logic        igent;
        logic        drv;
        logic        irv;
        logic        derr;
        logic        ierr;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
        logic [3:0]  hprot;
        logic [31:0] hwdata;
        logic [31:0] drdata;
        logic [31:0] irdata;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ireq, igent, irv, ierr;
    logic [31:0] iaddr, irdata;
    logic        dreq, dgnt, drv, dwe, derr;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwdata, drdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hburst, hsize;
    logic        hmastlock, hwrite, hready, hresp;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: is a transfer outstanding, who owns it, the
    // last write data accepted from the LSU, and who was granted last.
    logic        m_valid;
    logic        m_owner_data;
    logic [31:0] m_hwdata;
    logic        m_last_data;
    in_t         cur;
    vec_t        tbl [NV];

    always #5 clk = ~clk;

    ahbl_dual_master_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .sys_clk_i        (clk),
        .sys_rstn_i       (rstn),
        .instr_req_i      (ireq),
        .instr_gnt_o      (igent),
        .instr_rvalid_o   (irv),
        .instr_addr_i     (iaddr),
        .instr_rdata_o    (irdata),
        .instr_err_o      (ierr),
        .data_req_i       (dreq),
        .data_gnt_o       (dgnt),
        .data_rvalid_o    (drv),
        .data_we_i        (dwe),
        .data_be_i        (dbe),
        .data_addr_i      (daddr),
        .data_wdata_i     (dwdata),
        .data_rdata_o     (drdata),
        .data_err_o       (derr),
        .ahbl_haddr_o     (haddr),
        .ahbl_hburst_o    (hburst),
        .ahbl_hmastlock_o (hmastlock),
        .ahbl_hprot_o     (hprot),
        .ahbl_hsize_o     (hsize),
        .ahbl_htrans_o    (htrans),
        .ahbl_hwdata_o    (hwdata),
        .ahbl_hwrite_o    (hwrite),
        .ahbl_hrdata_i    (hrdata),
        .ahbl_hready_i    (hready),
        .ahbl_hresp_i     (hresp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        cur    = v;
        rstn   = v.rstn;
        ireq   = v.ireq;
        iaddr  = v.iaddr;
        dreq   = v.dreq;
        dwe    = v.dwe;
        dbe    = v.dbe;
        daddr  = v.daddr;
        dwdata = v.dwdata;
        hrdata = v.hrdata;
        hready = v.hready;
        hresp  = v.hresp;
        #3;
    endtask

    function automatic logic model_wins_data(input in_t v);
        logic wd;
        wd = v.dreq;
`ifdef ARB_ROUND_ROBIN_EN
        if (v.dreq && v.ireq && m_last_data) wd = 1'b0;
`endif
        return wd;
    endfunction

    function automatic out_t model_out(input in_t v);
        out_t o;
        logic any, wd, err1, g, rv;
        logic [1:0] lo;
        logic [2:0] sz;
        any  = v.ireq | v.dreq;
        wd   = model_wins_data(v);
        err1 = v.hresp && !v.hready;
        g    = any && v.hready && !err1;
        rv   = m_valid && v.hready;
        o.dgnt   = g && wd;
        o.igent  = g && !wd;
        o.drv    = rv && m_owner_data;
        o.irv    = rv && !m_owner_data;
        o.derr   = o.drv && v.hresp;
        o.ierr   = o.irv && v.hresp;
        o.drdata = o.drv ? v.hrdata : 32'h0;
        o.irdata = o.irv ? v.hrdata : 32'h0;
        o.htrans = (any && !err1) ? NSQ : IDL;
        sz = SZW;
        lo = 2'b00;
        if ($countones(v.dbe) == 1) begin
            sz = SZB;
            for (int i = 0; i < 4; i++) if (v.dbe[i]) lo = 2'(i);
        end else if (v.dbe == 4'b0011) begin
            sz = SZH;
        end else if (v.dbe == 4'b1100) begin
            sz = SZH;
            lo = 2'b10;
        end
        o.haddr  = 32'h0;
        o.hsize  = SZW;
        o.hwrite = 1'b0;
        o.hprot  = PF;
        if (any) begin
            if (wd) begin
                o.haddr  = {v.daddr[31:2], lo};
                o.hsize  = sz;
                o.hwrite = v.dwe;
                o.hprot  = PD;
            end else begin
                o.haddr = v.iaddr;
            end
        end
        o.hwdata = m_hwdata;
        return o;
    endfunction

    task automatic check_out(input out_t e, input string tag);
        chk({tag, ".data_gnt"},     32'(dgnt),      32'(e.dgnt));
        chk({tag, ".instr_gnt"},    32'(igent),     32'(e.igent));
        chk({tag, ".data_rvalid"},  32'(drv),       32'(e.drv));
        chk({tag, ".instr_rvalid"}, 32'(irv),       32'(e.irv));
        chk({tag, ".data_err"},     32'(derr),      32'(e.derr));
        chk({tag, ".instr_err"},    32'(ierr),      32'(e.ierr));
        chk({tag, ".htrans"},       32'(htrans),    32'(e.htrans));
        chk({tag, ".haddr"},        haddr,          e.haddr);
        chk({tag, ".hsize"},        32'(hsize),     32'(e.hsize));
        chk({tag, ".hwrite"},       32'(hwrite),    32'(e.hwrite));
        chk({tag, ".hprot"},        32'(hprot),     32'(e.hprot));
        chk({tag, ".hwdata"},       hwdata,         e.hwdata);
        chk({tag, ".data_rdata"},   drdata,         e.drdata);
        chk({tag, ".instr_rdata"},  irdata,         e.irdata);
        chk({tag, ".hburst"},       32'(hburst),    32'h0);
        chk({tag, ".hmastlock"},    32'(hmastlock), 32'h0);
    endtask

    task automatic check_model(input string tag);
        check_out(model_out(cur), tag);
    endtask

    task automatic model_update(input in_t v);
        logic wd, g;
        wd = model_wins_data(v);
        g  = (v.ireq | v.dreq) && v.hready && !(v.hresp && !v.hready);
        if (!v.rstn) begin
            m_valid      = 1'b0;
            m_owner_data = 1'b0;
            m_hwdata     = 32'h0;
            m_last_data  = 1'b0;
        end else if (v.hready) begin
            m_valid = g;
            if (g) begin
                m_owner_data = wd;
                if (wd) m_hwdata = v.dwdata;
                m_last_data = wd;
            end
        end
    endtask

    task automatic advance();
        model_update(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('{N, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, 32'h0, Y, N});
        advance();
        advance();
    endtask

    initial begin
        in_t  r;
        logic exp_d;

        //        rstn ireq iaddr        dreq dwe be     daddr       dwdata        hrdata        rdy rsp    dg ig drv irv de ie htrans haddr      hsize hw hprot hwdata         drdata        irdata
        tbl[0]  = '{'{Y, N, 32'h0,   N, N, 4'h0, 32'h0,   32'h0,        32'h0,        Y, N}, '{N, N, N, N, N, N, IDL, 32'h0,   SZW, N, PF, 32'h0,        32'h0,        32'h0}};
        tbl[1]  = '{'{Y, Y, 32'h0,   Y, N, 4'hF, 32'h100, 32'h0,        32'h11111111, Y, N}, '{Y, N, N, N, N, N, NSQ, 32'h100, SZW, N, PD, 32'h0,        32'h0,        32'h0}};
        tbl[2]  = '{'{Y, Y, 32'h0,   N, N, 4'hF, 32'h100, 32'h0,        32'hCAFEF00D, Y, N}, '{N, Y, Y, N, N, N, NSQ, 32'h0,   SZW, N, PF, 32'h0,        32'hCAFEF00D, 32'h0}};
        tbl[3]  = '{'{Y, N, 32'h0,   N, N, 4'h0, 32'h0,   32'h0,        32'h12345678, Y, N}, '{N, N, N, Y, N, N, IDL, 32'h0,   SZW, N, PF, 32'h0,        32'h0,        32'h12345678}};
        tbl[4]  = '{'{Y, N, 32'h0,   Y, Y, 4'h4, 32'h20,  32'hAABBCCDD, 32'h0,        Y, N}, '{Y, N, N, N, N, N, NSQ, 32'h22,  SZB, Y, PD, 32'h0,        32'h0,        32'h0}};
        tbl[5]  = '{'{Y, N, 32'h0,   N, N, 4'h0, 32'h0,   32'h0,        32'h55,       Y, N}, '{N, N, Y, N, N, N, IDL, 32'h0,   SZW, N, PF, 32'hAABBCCDD, 32'h55,       32'h0}};
        tbl[6]  = '{'{Y, N, 32'h0,   Y, N, 4'hF, 32'h40,  32'h0BAD0BAD, 32'h0,        Y, N}, '{Y, N, N, N, N, N, NSQ, 32'h40,  SZW, N, PD, 32'hAABBCCDD, 32'h0,        32'h0}};
        tbl[7]  = '{'{Y, Y, 32'h80,  N, N, 4'h0, 32'h0,   32'h0,        32'h77,       N, Y}, '{N, N, N, N, N, N, IDL, 32'h80,  SZW, N, PF, 32'h0BAD0BAD, 32'h0,        32'h0}};
        tbl[8]  = '{'{Y, Y, 32'h80,  N, N, 4'h0, 32'h0,   32'h0,        32'hDEAD0001, Y, Y}, '{N, Y, Y, N, Y, N, NSQ, 32'h80,  SZW, N, PF, 32'h0BAD0BAD, 32'hDEAD0001, 32'h0}};
        tbl[9]  = '{'{Y, N, 32'h0,   Y, Y, 4'h3, 32'h30,  32'h01020304, 32'h99,       Y, N}, '{Y, N, N, Y, N, N, NSQ, 32'h30,  SZH, Y, PD, 32'h0BAD0BAD, 32'h0,        32'h99}};
        tbl[10] = '{'{N, N, 32'h0,   N, N, 4'h0, 32'h0,   32'h0,        32'h5,        N, N}, '{N, N, N, N, N, N, IDL, 32'h0,   SZW, N, PF, 32'h01020304, 32'h0,        32'h0}};
        tbl[11] = '{'{Y, N, 32'h0,   N, N, 4'h0, 32'h0,   32'h0,        32'h6,        Y, N}, '{N, N, N, N, N, N, IDL, 32'h0,   SZW, N, PF, 32'h0,        32'h0,        32'h0}};
        tbl[12] = '{'{Y, N, 32'h0,   Y, N, 4'h2, 32'h50,  32'h0,        32'h0,        Y, N}, '{Y, N, N, N, N, N, NSQ, 32'h51,  SZB, N, PD, 32'h0,        32'h0,        32'h0}};
        tbl[13] = '{'{Y, N, 32'h0,   Y, N, 4'h8, 32'h50,  32'h0,        32'h13,       Y, N}, '{Y, N, Y, N, N, N, NSQ, 32'h53,  SZB, N, PD, 32'h0,        32'h13,       32'h0}};
        tbl[14] = '{'{Y, N, 32'h0,   Y, N, 4'hC, 32'h50,  32'h0,        32'h14,       Y, N}, '{Y, N, Y, N, N, N, NSQ, 32'h52,  SZH, N, PD, 32'h0,        32'h14,       32'h0}};
        tbl[15] = '{'{Y, N, 32'h0,   Y, N, 4'h5, 32'h50,  32'h0,        32'h15,       Y, N}, '{Y, N, Y, N, N, N, NSQ, 32'h50,  SZW, N, PD, 32'h0,        32'h15,       32'h0}};
        tbl[16] = '{'{Y, N, 32'h0,   Y, N, 4'h1, 32'h50,  32'h0,        32'h16,       Y, N}, '{Y, N, Y, N, N, N, NSQ, 32'h50,  SZB, N, PD, 32'h0,        32'h16,       32'h0}};
        tbl[17] = '{'{Y, N, 32'h0,   N, N, 4'h0, 32'h0,   32'h0,        32'h17,       Y, N}, '{N, N, Y, N, N, N, IDL, 32'h0,   SZW, N, PF, 32'h0,        32'h17,       32'h0}};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].in);
            check_out(tbl[i].exp, $sformatf("row%0d", i));
            advance();
        end

        // Fetch data phase stretched by three wait states with a second fetch pending.
        do_reset();
        drive('{Y, Y, 32'h100, N, N, 4'h0, 32'h0, 32'h0, 32'h0, Y, N});
        check_model("ws_start");
        chk("ws_first_gnt", 32'(igent), 32'h1);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive('{Y, Y, 32'h104, N, N, 4'h0, 32'h0, 32'h0, 32'hF00, N, N});
            check_model($sformatf("ws_wait%0d", k));
            chk("ws_wait_gnt", 32'(igent | dgnt), 32'h0);
            chk("ws_wait_haddr", haddr, 32'h104);
            chk("ws_wait_htrans", 32'(htrans), 32'(NSQ));
            chk("ws_wait_rvalid", 32'(irv), 32'h0);
            advance();
        end
        drive('{Y, Y, 32'h104, N, N, 4'h0, 32'h0, 32'h0, 32'hF00D, Y, N});
        check_model("ws_release");
        chk("ws_release_rvalid", 32'(irv), 32'h1);
        chk("ws_release_rdata", irdata, 32'hF00D);
        chk("ws_release_gnt", 32'(igent), 32'h1);
        advance();
        drive('{Y, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, 32'hBEEF, Y, N});
        chk("ws_second_rvalid", 32'(irv), 32'h1);
        chk("ws_second_rdata", irdata, 32'hBEEF);
        advance();

        // Both ports requesting every cycle.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive('{Y, Y, 32'h300, Y, N, 4'hF, 32'h400, 32'h0, 32'(k), Y, N});
            check_model($sformatf("both%0d", k));
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            chk("both_data_gnt", 32'(dgnt), 32'(exp_d));
            chk("both_instr_gnt", 32'(igent), 32'(!exp_d));
            advance();
        end

        // Randomized cycles against the behavioural model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r.rstn   = ($urandom_range(0, 39) != 0);
            r.ireq   = 1'($urandom_range(0, 1));
            r.iaddr  = $urandom & 32'hFFFF_FFFC;
            r.dreq   = 1'($urandom_range(0, 1));
            r.dwe    = 1'($urandom_range(0, 1));
            r.dbe    = 4'($urandom_range(0, 15));
            r.daddr  = $urandom & 32'hFFFF_FFFC;
            r.dwdata = $urandom;
            r.hrdata = $urandom;
            r.hready = ($urandom_range(0, 3) != 0);
            r.hresp  = ($urandom_range(0, 9) == 0);
            drive(r);
            check_model($sformatf("rand%0d", k));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
